sc_shiftcommand_generator: RTL and testbench

Command source for the player-position shift register: converts the two raw active-low steering pushbuttons into single-cycle shift-selection commands. Each raw input is synchronized and debounced. A clean press emits one command. Holding the button emits auto-repeat commands. The output drives the position shifter's 2-bit shift-selection input directly (2'b01 = shift left/toward MSB, 2'b10 = shift right/toward LSB, 2'b00 = hold).

---
 rtl/sc_shiftcommand_generator.sv | 137 +++++++++++++
 tb/tb_sc_shiftcommand_generator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_shiftcommand_generator.sv
// Steering pushbutton front end: synchronize, debounce and turn
// presses into single-cycle shift-selection pulses with auto-repeat.
module sc_shiftcommand_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic       SC_SHIFTCMD_CLOCK_50,
  input  logic       SC_SHIFTCMD_RESET_InHigh,
  input  logic       SC_SHIFTCMD_left_InLow,
  input  logic       SC_SHIFTCMD_right_InLow,
  input  logic       SC_SHIFTCMD_enable_InLow,
  output logic [1:0] SC_SHIFTCMD_shiftselection_Out,
  output logic [1:0] SC_SHIFTCMD_pressed_Out
);

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_LOCK
  } state_t;

  logic        w_clk;
  logic        w_rst;
  logic        w_en_n;
  logic [1:0]  r_meta;
  logic [1:0]  r_sync;
  logic [1:0]  r_deb;
  logic [31:0] r_cnt [2];
  state_t      r_state;
  logic [31:0] r_timer;
  logic [1:0]  r_dir;
  logic [1:0]  r_cmd;
  logic [1:0]  w_first;
  logic [1:0]  w_own;
  logic [31:0] w_last;

  assign w_clk  = SC_SHIFTCMD_CLOCK_50;
  assign w_rst  = SC_SHIFTCMD_RESET_InHigh;
  assign w_en_n = SC_SHIFTCMD_enable_InLow;

  // debounced {left,right} mapped to command encoding (left -> 01)
  assign w_first = {r_deb[0], r_deb[1]};
  // debounced pattern meaning "only the active button is held"
  assign w_own   = {r_dir[0], r_dir[1]};
  assign w_last  = (r_state == S_HOLD) ? HOLD_LAST : REP_LAST;

  // two-flop synchronizer, inverted so 1 = pressed
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {~SC_SHIFTCMD_left_InLow, ~SC_SHIFTCMD_right_InLow};
      r_sync <= r_meta;
    end
  end

  // per-button debounce: accept a change after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_deb <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_cnt[i] <= 32'd0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_sync[i];
          r_cnt[i] <= 32'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

  // command FSM: first press, hold delay, auto-repeat, direction lockout
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_timer <= 32'd0;
      r_dir   <= 2'b00;
      r_cmd   <= 2'b00;
    end else begin
      r_cmd <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_en_n) begin
            if (|r_deb) r_state <= S_LOCK;
          end else if (r_deb == 2'b11) begin
            r_state <= S_LOCK;
          end else if (r_deb != 2'b00) begin
            r_cmd   <= w_first;
            r_dir   <= w_first;
            r_timer <= 32'd0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (w_en_n) begin
            r_state <= S_LOCK;
          end else if (r_deb == w_own) begin
            if (r_timer == w_last) begin
              r_cmd   <= r_dir;
              r_timer <= 32'd0;
              r_state <= S_REPEAT;
            end else begin
              r_timer <= r_timer + 32'd1;
            end
          end else if (r_deb == 2'b00) begin
            r_timer <= 32'd0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= 32'd0;
            r_state <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (!w_en_n && r_deb == 2'b00) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SC_SHIFTCMD_shiftselection_Out = r_cmd;
  assign SC_SHIFTCMD_pressed_Out        = r_deb;

endmodule

// File: tb/tb_sc_shiftcommand_generator.sv
// Bench for sc_shiftcommand_generator: directed scenarios plus
// random button activity checked against a behavioural model.
module tb_sc_shiftcommand_generator;

  localparam int DEB = 4;
  localparam int H   = 20;
  localparam int R   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       l   = 1'b1;
  logic       r   = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel;
  logic [1:0] prs;

  sc_shiftcommand_generator #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .SC_SHIFTCMD_CLOCK_50          (clk),
    .SC_SHIFTCMD_RESET_InHigh      (rst),
    .SC_SHIFTCMD_left_InLow        (l),
    .SC_SHIFTCMD_right_InLow       (r),
    .SC_SHIFTCMD_enable_InLow      (en),
    .SC_SHIFTCMD_shiftselection_Out(sel),
    .SC_SHIFTCMD_pressed_Out       (prs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int p_t[$];
  logic [1:0] p_v[$];

  // model state
  logic [1:0] m_meta, m_sync, m_deb, m_cmd;
  bit hl[$];
  bit hr[$];
  int mode;
  int age;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit all_diff(input bit q[$], input bit d);
    if (q.size() < DEB) return 1'b0;
    foreach (q[i]) if (q[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_meta = 2'b00;
    m_sync = 2'b00;
    m_deb  = 2'b00;
    m_cmd  = 2'b00;
    mode   = 0;
    age    = 0;
    hl.delete();
    hr.delete();
  endtask

  // mode: 0 idle, 1 left active, 2 right active, 3 locked out
  task automatic m_edge();
    logic [1:0] p, nd, cmd, own;
    p   = m_deb;
    nd  = m_deb;
    cmd = 2'b00;
    hl.push_back(m_sync[1]);
    if (hl.size() > DEB) void'(hl.pop_front());
    if (all_diff(hl, m_deb[1])) nd[1] = ~m_deb[1];
    hr.push_back(m_sync[0]);
    if (hr.size() > DEB) void'(hr.pop_front());
    if (all_diff(hr, m_deb[0])) nd[0] = ~m_deb[0];
    if (en) begin
      if (mode != 0 || p != 2'b00) mode = 3;
    end else begin
      case (mode)
        0: begin
          if (p == 2'b11) mode = 3;
          else if (p == 2'b10) begin cmd = 2'b01; mode = 1; age = 0; end
          else if (p == 2'b01) begin cmd = 2'b10; mode = 2; age = 0; end
        end
        1, 2: begin
          own = (mode == 1) ? 2'b10 : 2'b01;
          if (p == own) begin
            age++;
            if (age == H || (age > H && (age - H) % R == 0))
              cmd = 2'(mode);
          end else if (p == 2'b00) mode = 0;
          else mode = 3;
        end
        default: if (p == 2'b00) mode = 0;
      endcase
    end
    m_sync = m_meta;
    m_meta = {~l, ~r};
    m_deb  = nd;
    m_cmd  = cmd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_edge();
    #1;
    cyc++;
    check("sel", sel, m_cmd);
    check("prs", prs, m_deb);
    if (sel != 2'b00) begin
      p_t.push_back(cyc);
      p_v.push_back(sel);
    end
  endtask

  task automatic clr();
    p_t.delete();
    p_v.delete();
  endtask

  int c0;
  int n01;
  int n10;
  int exp_off[6] = '{7, 27, 35, 43, 51, 59};

  initial begin
    m_reset();
    #1;
    check("rst_sel", sel, 2'b00);
    check("rst_prs", prs, 2'b00);
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    // single tap
    clr(); c0 = cyc; l = 1'b0;
    repeat (10) tick();
    l = 1'b1;
    repeat (30) tick();
    check("tap_n", p_t.size(), 1);
    if (p_t.size() == 1) begin
      check("tap_t", p_t[0] - c0, 7);
      check("tap_v", p_v[0], 2'b01);
    end

    // hold with auto-repeat
    clr(); c0 = cyc; r = 1'b0;
    repeat (60) tick();
    r = 1'b1;
    repeat (30) tick();
    check("hold_n", p_t.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < p_t.size()) begin
        check("hold_t", p_t[i] - c0, exp_off[i]);
        check("hold_v", p_v[i], 2'b10);
      end
    end

    // bounce
    clr();
    for (int i = 0; i < 30; i++) begin
      l = (i % 4 < 2) ? 1'b0 : 1'b1;
      tick();
    end
    l = 1'b1;
    repeat (10) tick();
    check("bnc_n", p_t.size(), 0);

    // direction change
    clr(); l = 1'b0;
    repeat (15) tick();
    r = 1'b0;
    repeat (30) tick();
    l = 1'b1;
    repeat (30) tick();
    r = 1'b1;
    repeat (20) tick();
    n01 = 0; n10 = 0;
    foreach (p_v[i]) begin
      if (p_v[i] == 2'b01) n01++;
      if (p_v[i] == 2'b10) n10++;
    end
    check("dir_n01", n01, 1);
    check("dir_n10", n10, 0);
    clr(); r = 1'b0;
    repeat (15) tick();
    r = 1'b1;
    repeat (15) tick();
    check("dir_new_n", p_t.size(), 1);
    if (p_t.size() == 1) check("dir_new_v", p_v[0], 2'b10);

    // pause
    clr(); l = 1'b0;
    repeat (10) tick();
    check("pause_first", p_t.size(), 1);
    clr(); en = 1'b1;
    repeat (40) tick();
    l = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    repeat (10) tick();
    check("pause_n", p_t.size(), 0);

    // reset mid-repeat
    clr(); l = 1'b0;
    repeat (36) tick();
    #3 rst = 1'b1;
    #1;
    check("ar_sel", sel, 2'b00);
    check("ar_prs", prs, 2'b00);
    m_reset();
    repeat (2) tick();
    rst = 1'b0;
    clr(); c0 = cyc;
    repeat (12) tick();
    check("rst_n", p_t.size(), 1);
    if (p_t.size() == 1) check("rst_lat", p_t[0] - c0, 7);
    l = 1'b1;
    repeat (20) tick();

    // simultaneous press
    clr(); l = 1'b0; r = 1'b0;
    repeat (30) tick();
    check("sim_n", p_t.size(), 0);
    check("sim_prs", prs, 2'b11);
    l = 1'b1; r = 1'b1;
    repeat (15) tick();

    // random activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) l = ~l;
      if ($urandom_range(0, 39) == 0) r = ~r;
      if ($urandom_range(0, 79) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #1;
        check("rnd_rst_sel", sel, 2'b00);
        check("rnd_rst_prs", prs, 2'b00);
        m_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
